add16_arbiter: RTL and testbench

- Shares one 16-bit ripple adder (Add16 instance, carry-out discarded) among N_REQ requesters.
- Requesters present operand pairs on per-port valid/ready handshakes; a round-robin arbiter grants one request at a time.
- The block sequences the addition and holds the tagged result on a valid/ready output port until it is consumed.
- Sits between ALU-side clients (address generators, counters, accumulators) and the single shared adder.

---
 rtl/add16_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_add16_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add16_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : add16_arbiter (with helper module add16)
//  Purpose  : Shares a single 16-bit ripple-carry adder among N_REQ clients.
//             A round-robin arbiter picks one pending operand pair per idle
//             cycle. The pair is latched, summed in the following cycle and
//             held on a valid/ready result port until it is consumed.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous, active-high reset
//             req_valid  - per-requester "operand pair pending"
//             req_ready  - per-requester grant strobe (one-hot or zero)
//             req_a/b    - packed operands, requester i at [16i+15:16i]
//             out_valid  - result held on out_sum/out_tag
//             out_ready  - consumer accepts result
//             out_sum    - (a+b) mod 2^16 of the granted request
//             out_tag    - index of the requester that produced out_sum
//             busy       - high whenever the sequencer is not idle
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// add16 : plain 16-bit ripple-carry adder, no carry-in.
// ----------------------------------------------------------------------------
module add16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_sum,
   output logic        o_cout
);

   logic [16:0] w_carry;

   assign w_carry[0] = 1'b0;

   for (genvar i = 0; i < 16; i++) begin : g_bit
      assign o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
      assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout = w_carry[16];

endmodule

// ----------------------------------------------------------------------------
// add16_arbiter : round-robin front end around one shared add16.
// ----------------------------------------------------------------------------
module add16_arbiter #(
   parameter  int N_REQ = 4,
   localparam int TAG_W = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [16*N_REQ-1:0]  req_a,
   input  logic [16*N_REQ-1:0]  req_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_sum,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             r_state;
   logic [TAG_W-1:0]   r_rr_ptr;
   logic [15:0]        r_op_a;
   logic [15:0]        r_op_b;
   logic [TAG_W-1:0]   r_op_tag;
   logic [15:0]        r_out_sum;
   logic [TAG_W-1:0]   r_out_tag;
   logic               r_out_valid;
   logic               r_busy;

   logic               w_found;
   logic [TAG_W-1:0]   w_winner;
   logic [TAG_W-1:0]   w_scan;
   logic [15:0]        w_sel_a;
   logic [15:0]        w_sel_b;
   logic [15:0]        w_add_sum;
   logic               w_unused_cout;

   // Increment modulo N_REQ; N_REQ need not be a power of two.
   function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] v);
      return (v == TAG_W'(N_REQ - 1)) ? '0 : v + TAG_W'(1);
   endfunction

   // Round-robin search: walk rr_ptr, rr_ptr+1, ... (mod N_REQ) and keep the
   // first requester found valid. w_scan never leaves 0..N_REQ-1, so the
   // index into req_valid is always in range.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_rr_ptr;
      w_scan   = r_rr_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req_valid[w_scan]) begin
            w_found  = 1'b1;
            w_winner = w_scan;
         end
         w_scan = wrap_inc(w_scan);
      end
   end

   // Operand slice of the current winner.
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_winner == TAG_W'(i)) begin
            w_sel_a = req_a[16*i +: 16];
            w_sel_b = req_b[16*i +: 16];
         end
      end
   end

   // Grant is combinational so the requester sees it in the same cycle the
   // operands are sampled; only the idle state may grant.
   always_comb begin
      req_ready = '0;
      if (r_state == IDLE && w_found) begin
         req_ready[w_winner] = 1'b1;
      end
   end

   // Shared adder is fed only from the operand registers, so requesters may
   // change their inputs right after the grant without disturbing the add.
   add16 u_add16 (
      .i_a    (r_op_a),
      .i_b    (r_op_b),
      .o_sum  (w_add_sum),
      .o_cout (w_unused_cout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_op_tag    <= '0;
         r_out_sum   <= '0;
         r_out_tag   <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_op_a   <= w_sel_a;
                  r_op_b   <= w_sel_b;
                  r_op_tag <= w_winner;
                  r_rr_ptr <= wrap_inc(w_winner);
                  r_busy   <= 1'b1;
                  r_state  <= ISSUE;
               end
            end
            ISSUE: begin
               r_out_sum   <= w_add_sum;
               r_out_tag   <= r_op_tag;
               r_out_valid <= 1'b1;
               r_state     <= HOLD;
            end
            HOLD: begin
               // Result and tag stay put until the consumer takes them; they
               // also keep their value afterwards (qualified by out_valid).
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_tag   = r_out_tag;
   assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_add16_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add16_arbiter
//  Purpose  : Self-checking bench for add16_arbiter (N_REQ = 4). A predictor
//             models arbitration and result expectations; a monitor compares
//             every presented result against a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add16_arbiter;

   localparam int N  = 4;
   localparam int TW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [16*N-1:0]   req_a;
   logic [16*N-1:0]   req_b;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_sum;
   logic [TW-1:0]     out_tag;
   logic              busy;

   add16_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [15:0]   sum;
   } exp_t;

   int          total = 0;
   int          bad   = 0;
   exp_t        sb[$];
   int          grants[$];
   int          n_done = 0;
   logic [15:0] last_sum = '0;
   int          last_tag = 0;
   logic [N-1:0] g_rdy = '0;
   bit          chk_en = 1'b0;
   bit          auto_drop = 1'b0;

   // Reference model state: phase 0 = idle, 1 = adding, 2 = holding result.
   int          m_phase = 0;
   int          m_rr    = 0;
   int          p_w;
   logic [N-1:0] p_exp_rdy;
   logic [15:0] p_a;
   logic [15:0] p_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int rr);
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   // Predictor: decides what the block must show this cycle and what it will
   // do at the next edge, from the arbitration rules alone.
   always @(negedge clk) begin
      if (chk_en) begin
         p_w = (m_phase == 0) ? pick(req_valid, m_rr) : -1;
         p_exp_rdy = '0;
         if (p_w >= 0) p_exp_rdy[p_w] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(p_exp_rdy));
         check("out_valid", 32'(out_valid), 32'(m_phase == 2));
         check("busy",      32'(busy),      32'(m_phase != 0));
         g_rdy = req_ready;
         if (reset) begin
            m_phase = 0;
            m_rr    = 0;
         end else begin
            case (m_phase)
               0: if (p_w >= 0) begin
                     p_a = req_a[16*p_w +: 16];
                     p_b = req_b[16*p_w +: 16];
                     sb.push_back('{tag: TW'(p_w), sum: 16'(p_a + p_b)});
                     grants.push_back(p_w);
                     m_rr    = (p_w + 1) % N;
                     m_phase = 1;
                  end
               1: m_phase = 2;
               default: if (out_ready) m_phase = 0;
            endcase
         end
      end
   end

   // In-flight work is discarded by a reset edge.
   always @(posedge clk) begin
      if (reset) sb.delete();
   end

   // Monitor: every presented result must match the oldest expectation.
   always @(negedge clk) begin
      if (chk_en && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got sum %h tag %0d, expected none", out_sum, out_tag);
         end else begin
            check("out_sum", 32'(out_sum), 32'(sb[0].sum));
            check("out_tag", 32'(out_tag), 32'(sb[0].tag));
            if (out_ready) begin
               last_sum = out_sum;
               last_tag = int'(out_tag);
               n_done++;
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_drop) req_valid = req_valid & ~g_rdy;
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic do_reset();
      req_valid = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_more(input int k, input int budget);
      int target = n_done + k;
      for (int c = 0; c < budget && n_done < target; c++) tick();
      check("wait_results_timeout", 32'(n_done >= target), 32'd1);
   endtask

   task automatic wait_busy(input int budget);
      for (int c = 0; c < budget && busy !== 1'b1; c++) tick();
      check("wait_grant_timeout", 32'(busy), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      for (int c = 0; c < budget && out_valid !== 1'b1; c++) tick();
      check("wait_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic drain();
      req_valid = '0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && busy !== 1'b0; c++) tick();
      check("drain_busy", 32'(busy), 32'd0);
      check("drain_scoreboard", 32'(sb.size()), 32'd0);
   endtask

   task automatic reset_mid(input bit in_hold);
      int base;
      int gbase;
      do_reset();
      auto_drop = 1'b1;
      out_ready = 1'b1;
      set_req(1, 16'h0005, 16'h0006);     // moves rr_ptr away from 0
      wait_more(1, 20);
      out_ready = 1'b0;
      set_req(3, 16'h0300, 16'h0030);
      wait_busy(10);                      // now in the adding cycle
      if (in_hold) tick();                // now holding the result
      base = n_done;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_out_valid", 32'(out_valid), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      gbase = grants.size();
      for (int i = 0; i < N; i++) set_req(i, 16'(16'h1000 * i + 1), 16'(i + 2));
      out_ready = 1'b1;
      wait_more(4, 60);
      check("rst_mid_first_winner", (grants.size() > gbase) ? grants[gbase] : 32'hFFFF_FFFF, 32'd0);
      check("rst_mid_result_count", 32'(n_done - base), 32'd4);
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s_hold;
      logic [TW-1:0] t_hold;
      int base;

      reset = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      out_ready = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_sum",   32'(out_sum),   32'd0);
      check("reset_out_tag",   32'(out_tag),   32'd0);
      check("reset_busy",      32'(busy),      32'd0);

      // Single request.
      auto_drop = 1'b1;
      out_ready = 1'b1;
      set_req(0, 16'h1234, 16'h1111);
      wait_more(1, 20);
      check("single_sum", 32'(last_sum), 32'h2345);
      check("single_tag", 32'(last_tag), 32'd0);
      tick();
      check("single_idle_busy", 32'(busy), 32'd0);

      // Wrap-around arithmetic.
      set_req(2, 16'hFFFF, 16'h0001);
      wait_more(1, 20);
      check("wrap1_sum", 32'(last_sum), 32'h0000);
      check("wrap1_tag", 32'(last_tag), 32'd2);
      set_req(2, 16'h8000, 16'h8000);
      wait_more(1, 20);
      check("wrap2_sum", 32'(last_sum), 32'h0000);

      // Round-robin with all four continuously valid.
      do_reset();
      auto_drop = 1'b0;
      grants.delete();
      for (int i = 0; i < N; i++) set_req(i, 16'(16'h0101 * (i + 1)), 16'(16'h1000 * (i + 1)));
      for (int c = 0; c < 40 && grants.size() < 5; c++) tick();
      req_valid = '0;
      check("rr_grant_count", 32'(grants.size() >= 5), 32'd1);
      for (int k = 0; k < 5 && k < grants.size(); k++) check("rr_order", grants[k], k % N);
      drain();

      // Backpressure.
      do_reset();
      auto_drop = 1'b1;
      out_ready = 1'b0;
      grants.delete();
      for (int i = 0; i < N; i++) set_req(i, 16'(16'h0A00 + i), 16'(16'h00B0 * (i + 1)));
      wait_valid(10);
      s_hold = out_sum;
      t_hold = out_tag;
      base = n_done;
      repeat (10) tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum_stable", 32'(out_sum), 32'(s_hold));
      check("bp_tag_stable", 32'(out_tag), 32'(t_hold));
      check("bp_no_new_grant", 32'(grants.size()), 32'd1);
      out_ready = 1'b1;
      tick();
      tick();
      check("bp_next_grant", (grants.size() >= 2) ? grants[1] : 32'hFFFF_FFFF, 32'd1);
      wait_more(4 - (n_done - base), 40);
      drain();

      // Reset during the adding cycle and during hold.
      reset_mid(1'b0);
      reset_mid(1'b1);

      // Operand change right after the grant.
      auto_drop = 1'b1;
      out_ready = 1'b1;
      set_req(1, 16'h0100, 16'h0011);
      wait_busy(10);
      req_a[16 +: 16] = 16'hAAAA;
      wait_more(1, 20);
      check("late_change_sum", 32'(last_sum), 32'h0111);
      check("late_change_tag", 32'(last_tag), 32'd1);
      drain();

      // Randomized traffic; operands only change while not pending.
      auto_drop = 1'b0;
      for (int c = 0; c < 600; c++) begin
         tick();
         out_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || g_rdy[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               req_a[16*i +: 16] = 16'($urandom);
               req_b[16*i +: 16] = 16'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
